fht_input_loader: RTL and testbench
===================================

# fht_input_loader

Front-end writer for the FHT core: accepts a stream of time-domain samples over a valid/ready handshake and writes them into the four data RAM banks in bit-reversed order, which is the order `fht_control` reads them in. Once a full frame is written, it pulses `fht_control`'s start input and holds off the next frame until the controller's ready flag shows the transform has finished. It sits between the sample source and the FHT memory/`fht_control` pair.

## Interface
Parameters:
- N_POINT, 256, transform size; power of two, ≥16.
- D_BIT, 16, sample width.
- A_BIT (derived, not overridable), $clog2(N_POINT)-2, per-bank address width.

Ports (one clock; reset is synchronous and active-high):
- iCLK  in  1  clock; all logic on its rising edge.
- iRESET  in  1  synchronous active-high reset.
- iDATA  in  D_BIT  input sample.
- iVALID  in  1  iDATA is valid.
- oREADY  out  1  loader accepts a sample this cycle.
- oDATA_WR  out  D_BIT  write data to the RAM banks.
- oADDR_WR  out  A_BIT  write address, shared by all banks.
- oWE  out  4  one-hot bank write enables; bit b selects bank b.
- oSTART  out  1  one-cycle start pulse to fht_control iSTART.
- iFHT_RDY  in  1  fht_control oRDY; 1 = idle, 0 = transform running.
- oBUSY  out  1  high in every state except LOAD.
- oDONE  out  1  one-cycle pulse when a transform completes.

## Operation
- Index mapping: sample n (0..N_POINT-1) has r = bit-reverse of n over log2(N_POINT) bits. Bank = r[1:0]. Address = r[log2(N_POINT)-1:2].
- FSM states: LOAD, FLUSH, FIRE, WAIT_ACK, WAIT_DONE. Reset state: LOAD.
- LOAD:
  - oREADY=1.
  - Each handshake (iVALID & oREADY) captures iDATA, maps the current value of cnt, and increments cnt.
  - cnt is log2(N_POINT) bits, reset 0.
  - The handshake that accepts sample N_POINT-1 moves the FSM to FLUSH and wraps cnt to 0.
- FLUSH:
  - oREADY=0.
  - Stay while iFHT_RDY=0, so a start is never issued to a busy controller.
  - Go to FIRE when iFHT_RDY=1.
- FIRE:
  - oSTART=1 for exactly this one cycle.
  - Always go to WAIT_ACK next.
- WAIT_ACK: wait for iFHT_RDY=0, then go to WAIT_DONE. No timeout.
- WAIT_DONE: wait for iFHT_RDY=1, then go to LOAD. oDONE=1 in the cycle the FSM re-enters LOAD.
- Write port: registered. For a handshake at edge k, oWE/oADDR_WR/oDATA_WR are valid during the cycle after edge k. oWE=0 otherwise. oADDR_WR/oDATA_WR hold their last value when not writing.
- iVALID while oREADY=0: ignored. No sample is consumed and no write is made.
- iFHT_RDY is sampled only in FLUSH, WAIT_ACK and WAIT_DONE.
- Reset mid-frame or mid-transform:
  - All state returns to reset values and any partial frame is discarded.
  - The next accepted sample is index 0.
  - No oSTART or oDONE is generated by the reset.
- Reset values: oREADY=1 (state LOAD), oWE=0, oADDR_WR=0, oDATA_WR=0, oSTART=0, oBUSY=0, oDONE=0.

## Timing
- Throughput: one sample per cycle in LOAD.
- A full frame with no source gaps takes N_POINT cycles of oREADY=1.
- Last handshake at edge k:
  - The last write is presented in cycle k+1, with the FSM in FLUSH.
  - With iFHT_RDY=1, oSTART is high in cycle k+2.
  - The last write is therefore always committed before the start edge.
- oBUSY rises in the cycle after the last handshake.
- oREADY=0 from the cycle after the last handshake until the FSM re-enters LOAD.
- oREADY rises in the cycle after iFHT_RDY is first sampled 1 in WAIT_DONE. oDONE pulses in that same cycle.
- If iFHT_RDY is still 1 for some cycles after oSTART (controller latency), the FSM stays in WAIT_ACK with no re-issue of oSTART.

## Test plan
- N_POINT=16, gap-free stream iDATA=100+n, iFHT_RDY=1:
  - 16 writes on consecutive cycles.
  - n=1 → oWE=4'b0001, addr 2, data 101.
  - n=3 → oWE=4'b0001, addr 3.
  - n=5 → oWE=4'b0100, addr 2.
  - n=15 → oWE=4'b1000, addr 3.
  - oSTART high exactly 2 cycles after the 16th handshake.
- Random iVALID gaps (~50%): same bank/address/data set as the gap-free case, cnt advances only on handshakes, and oWE count equals 16.
- iFHT_RDY held 0 for 20 cycles after the frame: FSM stays in FLUSH, oSTART=0 throughout, and oSTART pulses 1 cycle after iFHT_RDY goes 1.
- After oSTART, drive iFHT_RDY high 3 cycles, low 50, then high:
  - oREADY=0 and iVALID ignored during the whole sequence.
  - oDONE and oREADY go high 1 cycle after iFHT_RDY returns high.
  - The next frame starts at n=0.
- Assert iRESET after sample 7, then send a full frame:
  - No oSTART after sample 7.
  - After reset, writes restart at n=0 → bank 0, addr 0.
  - oSTART fires only after 16 new samples.
- Assert iRESET during WAIT_DONE: outputs return to reset values the next cycle, oDONE is never pulsed, and oREADY=1.

Source files
------------

// File: rtl/fht_input_loader.sv
// Streams samples into the four FHT data banks in bit-reversed order, then
// hands the frame to fht_control and holds off new input until it finishes.
module fht_input_loader #(
  parameter  int N_POINT = 256,
  parameter  int D_BIT   = 16,
  localparam int A_BIT   = $clog2(N_POINT) - 2
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  output logic [D_BIT-1:0] oDATA_WR,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [3:0]       oWE,
  output logic             oSTART,
  input  logic             iFHT_RDY,
  output logic             oBUSY,
  output logic             oDONE
);

  localparam int L_BIT = $clog2(N_POINT);
  localparam logic [L_BIT-1:0] CNT_LAST = L_BIT'(N_POINT - 1);

  typedef enum logic [2:0] {LOAD, FLUSH, FIRE, WAIT_ACK, WAIT_DONE} state_t;

  state_t           state_reg;
  logic [L_BIT-1:0] cnt_reg;
  logic [L_BIT-1:0] rev;
  logic             ready_reg;
  logic             busy_reg;
  logic             start_reg;
  logic             done_reg;
  logic [3:0]       we_reg;
  logic [A_BIT-1:0] addr_reg;
  logic [D_BIT-1:0] data_reg;
  logic             hs;

  generate
    for (genvar gi = 0; gi < L_BIT; gi++) begin : g_rev
      assign rev[gi] = cnt_reg[L_BIT-1-gi];
    end
  endgenerate

  // ready_reg is only ever high in LOAD, so it alone qualifies a handshake.
  assign hs = iVALID & ready_reg;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_reg <= LOAD;
      cnt_reg   <= '0;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      start_reg <= 1'b0;
      done_reg  <= 1'b0;
      we_reg    <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      start_reg <= 1'b0;
      done_reg  <= 1'b0;
      we_reg    <= '0;
      if (hs) begin
        we_reg   <= 4'b0001 << rev[1:0];
        addr_reg <= rev[L_BIT-1:2];
        data_reg <= iDATA;
      end
      case (state_reg)
        LOAD: begin
          if (hs) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_LAST) begin
              state_reg <= FLUSH;
              ready_reg <= 1'b0;
              busy_reg  <= 1'b1;
            end
          end
        end
        // The final write lands during FLUSH, so it is committed before start.
        FLUSH: begin
          if (iFHT_RDY) begin
            state_reg <= FIRE;
            start_reg <= 1'b1;
          end
        end
        FIRE: state_reg <= WAIT_ACK;
        WAIT_ACK: begin
          if (!iFHT_RDY) state_reg <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (iFHT_RDY) begin
            state_reg <= LOAD;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= LOAD;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign oREADY   = ready_reg;
  assign oBUSY    = busy_reg;
  assign oSTART   = start_reg;
  assign oDONE    = done_reg;
  assign oWE      = we_reg;
  assign oADDR_WR = addr_reg;
  assign oDATA_WR = data_reg;

endmodule

// File: tb/tb_fht_input_loader.sv
// Self-checking bench for fht_input_loader at N_POINT=16: table vectors,
// random-gap frames against a bit-reversal model, and reset corner cases.
module tb_fht_input_loader;

  localparam int N   = 16;
  localparam int D   = 16;
  localparam int A   = 2;
  localparam int LOG = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [D-1:0] data = '0;
  logic         valid = 1'b0;
  logic         fht_rdy = 1'b1;
  logic         ready;
  logic [D-1:0] data_wr;
  logic [A-1:0] addr_wr;
  logic [3:0]   we;
  logic         start;
  logic         busy;
  logic         done;

  fht_input_loader #(.N_POINT(N), .D_BIT(D)) dut (
    .iCLK(clk), .iRESET(rst), .iDATA(data), .iVALID(valid), .oREADY(ready),
    .oDATA_WR(data_wr), .oADDR_WR(addr_wr), .oWE(we), .oSTART(start),
    .iFHT_RDY(fht_rdy), .oBUSY(busy), .oDONE(done)
  );

  always #5 clk = ~clk;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Reference model state: samples accepted so far in the frame.
  bit           exp_ready = 1'b1;
  int           model_n = 0;
  int           frames = 0;
  int           wr_count = 0;
  logic [A-1:0] last_addr = '0;
  logic [D-1:0] last_data = '0;

  logic [3:0]   cap_we[N];
  logic [A-1:0] cap_addr[N];
  logic [D-1:0] cap_data[N];

  typedef struct {
    int           n;
    logic [3:0]   we;
    logic [A-1:0] addr;
  } vec_t;
  vec_t tbl[8];

  function automatic int bitrev(input int n);
    int r = 0;
    int v = n;
    for (int i = 0; i < LOG; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: compute the expected outcome of this edge and check every output.
  task automatic tick(input bit want_start, input bit want_done);
    bit         hs;
    int         r;
    logic [3:0] ew;
    hs = valid && exp_ready;
    @(posedge clk);
    #1;
    ew = 4'b0;
    if (hs) begin
      r = bitrev(model_n);
      ew = 4'(1 << (r % 4));
      last_addr = A'(r / 4);
      last_data = data;
      cap_we[model_n]   = we;
      cap_addr[model_n] = addr_wr;
      cap_data[model_n] = data_wr;
      model_n++;
      if (model_n == N) begin
        model_n = 0;
        exp_ready = 1'b0;
        frames++;
      end
    end
    if (want_done) exp_ready = 1'b1;
    if (we != 4'b0) wr_count++;
    check("we", 32'(we), 32'(ew));
    check("addr", 32'(addr_wr), 32'(last_addr));
    check("data", 32'(data_wr), 32'(last_data));
    check("ready", 32'(ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(!exp_ready));
    check("start", 32'(start), 32'(want_start));
    check("done", 32'(done), 32'(want_done));
    $display("cycle t=%0t hs=%0d we=%b addr=%0d data=%0d rdy=%0b start=%0b done=%0b",
             $time, hs, we, addr_wr, data_wr, ready, start, done);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ready = 1'b1;
    model_n = 0;
    last_addr = '0;
    last_data = '0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr", 32'(addr_wr), 32'd0);
    check("rst_data", 32'(data_wr), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
  endtask

  initial begin
    int f0;
    int c;
    tbl[0] = '{0,  4'b0001, 2'd0};
    tbl[1] = '{1,  4'b0001, 2'd2};
    tbl[2] = '{2,  4'b0001, 2'd1};
    tbl[3] = '{3,  4'b0001, 2'd3};
    tbl[4] = '{4,  4'b0100, 2'd0};
    tbl[5] = '{5,  4'b0100, 2'd2};
    tbl[6] = '{8,  4'b0010, 2'd0};
    tbl[7] = '{15, 4'b1000, 2'd3};

    do_reset();
    tick(0, 0);

    // Gap-free frame, controller idle.
    for (int n = 0; n < N; n++) begin
      valid = 1'b1;
      data = D'(100 + n);
      tick(0, 0);
    end
    valid = 1'b0;
    tick(1, 0);
    for (int i = 0; i < 8; i++) begin
      check("tbl_we", 32'(cap_we[tbl[i].n]), 32'(tbl[i].we));
      check("tbl_addr", 32'(cap_addr[tbl[i].n]), 32'(tbl[i].addr));
      check("tbl_data", 32'(cap_data[tbl[i].n]), 32'(100 + tbl[i].n));
    end

    // Controller latency then a long transform; input must be ignored.
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = D'($urandom);
      tick(0, 0);
    end
    fht_rdy = 1'b0;
    for (int i = 0; i < 50; i++) begin
      data = D'($urandom);
      tick(0, 0);
    end
    fht_rdy = 1'b1;
    tick(0, 1);
    valid = 1'b0;
    tick(0, 0);

    // Random-gap frame with the controller reported busy afterwards.
    fht_rdy = 1'b0;
    wr_count = 0;
    f0 = frames;
    c = 0;
    while (frames == f0 && c < 400) begin
      valid = 1'($urandom_range(0, 1));
      data = D'($urandom);
      tick(0, 0);
      c++;
    end
    check("gap_frame_complete", 32'(frames), 32'(f0 + 1));
    check("gap_frame_writes", 32'(wr_count), 32'd16);
    for (int i = 0; i < 20; i++) begin
      valid = 1'($urandom_range(0, 1));
      tick(0, 0);
    end
    valid = 1'b0;
    fht_rdy = 1'b1;
    tick(1, 0);
    fht_rdy = 1'b0;
    tick(0, 0);
    tick(0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0);
    fht_rdy = 1'b1;
    tick(0, 1);

    // Reset after 8 samples; the partial frame must be dropped.
    for (int n = 0; n < 8; n++) begin
      valid = 1'b1;
      data = D'(300 + n);
      tick(0, 0);
    end
    valid = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) tick(0, 0);
    for (int n = 0; n < N; n++) begin
      valid = 1'b1;
      data = D'(200 + n);
      tick(0, 0);
      if (n == 0) begin
        check("restart_we", 32'(we), 32'd1);
        check("restart_addr", 32'(addr_wr), 32'd0);
      end
    end
    valid = 1'b0;
    tick(1, 0);

    // Reset while waiting for the transform to finish.
    fht_rdy = 1'b0;
    tick(0, 0);
    tick(0, 0);
    fht_rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) tick(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
